// File: rtl/rx_line_writer.sv
// Frames received UART bytes into LF-terminated lines for the echo FIFO,
// counting complete lines pending and recovering from FIFO-full / over-length lines.
module rx_line_writer #(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              MAX_LINE   = 64,
    parameter logic [DATA_WIDTH-1:0]    LF_CODE    = 8'h0A,
    parameter bit                       STRIP_CR   = 1'b1,
    localparam int unsigned             LenW       = $clog2(MAX_LINE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_rx,
    input  logic [DATA_WIDTH-1:0] data_rx,
    input  logic                  full,
    input  logic                  line_ack,
    input  logic                  clr_ovf,
    output logic                  wr_en_fifo,
    output logic [DATA_WIDTH-1:0] wr_data_fifo,
    output logic                  line_done,
    output logic [LenW-1:0]       line_len,
    output logic [7:0]            lines_pending,
    output logic                  line_valid,
    output logic                  overflow
);

    localparam logic [DATA_WIDTH-1:0] CrCode  = DATA_WIDTH'(8'h0D);
    localparam logic [LenW-1:0]       MaxLen  = LenW'(MAX_LINE);
    localparam logic [LenW-1:0]       LastCnt = LenW'(MAX_LINE - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrop, StClose} state_e;

    state_e                state_q, state_d;
    logic [LenW-1:0]       count_q, count_d;
    logic                  lf_seen_q, lf_seen_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  line_done_q, line_done_d;
    logic [LenW-1:0]       line_len_q, line_len_d;
    logic [7:0]            pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  set_ovf;
    logic                  rx_valid;
    logic                  rx_lf;
    logic                  dec;

    // Stripped CR bytes behave as if no byte arrived at all.
    assign rx_valid = done_rx && !(STRIP_CR && (data_rx == CrCode));
    assign rx_lf    = (data_rx == LF_CODE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lf_seen_d   = lf_seen_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        line_done_d = 1'b0;
        line_len_d  = line_len_q;
        set_ovf     = 1'b0;
        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (full) begin
                        set_ovf = 1'b1;
                        if (!rx_lf) state_d = StDrop;
                    end else if (rx_lf) begin
                        wr_en_d     = 1'b1;
                        wr_data_d   = LF_CODE;
                        line_done_d = 1'b1;
                        line_len_d  = LenW'(1);
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = data_rx;
                        count_d   = LenW'(1);
                        state_d   = StCollect;
                    end
                end
            end
            StCollect: begin
                if (rx_valid) begin
                    if (full) begin
                        set_ovf   = 1'b1;
                        lf_seen_d = rx_lf;
                        state_d   = StClose;
                    end else if (rx_lf) begin
                        wr_en_d     = 1'b1;
                        wr_data_d   = LF_CODE;
                        line_done_d = 1'b1;
                        line_len_d  = count_q + LenW'(1);
                        count_d     = '0;
                        state_d     = StIdle;
                    end else if (count_q == LastCnt) begin
                        // Truncate: the terminator takes the last slot of the line.
                        wr_en_d     = 1'b1;
                        wr_data_d   = LF_CODE;
                        line_done_d = 1'b1;
                        line_len_d  = MaxLen;
                        set_ovf     = 1'b1;
                        count_d     = '0;
                        state_d     = StDrop;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = data_rx;
                        count_d   = count_q + LenW'(1);
                    end
                end
            end
            StClose: begin
                if (!full) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = LF_CODE;
                    line_done_d = 1'b1;
                    line_len_d  = count_q + LenW'(1);
                    count_d     = '0;
                    lf_seen_d   = 1'b0;
                    // An LF arriving in the closing cycle itself also ends the dropped tail.
                    state_d     = (lf_seen_q || (rx_valid && rx_lf)) ? StIdle : StDrop;
                end else if (rx_valid && rx_lf) begin
                    lf_seen_d = 1'b1;
                end
            end
            StDrop: begin
                if (rx_valid && rx_lf) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dec    = line_ack && (pend_q != 8'd0);
        pend_d = pend_q;
        if (line_done_d && !dec) begin
            if (pend_q != 8'hFF) pend_d = pend_q + 8'd1;
        end else if (!line_done_d && dec) begin
            pend_d = pend_q - 8'd1;
        end
        valid_d = (pend_d != 8'd0);
        ovf_d   = set_ovf ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            lf_seen_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            line_done_q <= 1'b0;
            line_len_q  <= '0;
            pend_q      <= 8'd0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lf_seen_q   <= lf_seen_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            line_done_q <= line_done_d;
            line_len_q  <= line_len_d;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_en_fifo    = wr_en_q;
    assign wr_data_fifo  = wr_data_q;
    assign line_done     = line_done_q;
    assign line_len      = line_len_q;
    assign lines_pending = pend_q;
    assign line_valid    = valid_q;
    assign overflow      = ovf_q;

endmodule
